// File: rtl/vend_payout_ctrl.sv
// Payout controller: queues change/bottle requests and
// drives one actuator at a time, waiting for its drop ack.
module vend_payout_ctrl #(
  parameter int PULSE_CYC   = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int PEND_W      = 4,
  parameter int INV_W       = 8,
  parameter int INV1_INIT   = 50,
  parameter int INV5_INIT   = 20,
  parameter int INVB_INIT   = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic rest1_req,
  input  logic rest5_req,
  input  logic bottle_req,
  input  logic ack1,
  input  logic ack5,
  input  logic ackb,
  input  logic refill,
  output logic drive1,
  output logic drive5,
  output logic driveb,
  output logic busy,
  output logic empty1,
  output logic empty5,
  output logic emptyb,
  output logic overflow,
  output logic fault
);

  typedef enum logic [1:0] {
    IDLE, DRIVE, WAIT_ACK, FAULT
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE, SEL_1, SEL_5, SEL_B
  } sel_t;

  localparam int CMAX =
    (PULSE_CYC > ACK_TIMEOUT) ? PULSE_CYC : ACK_TIMEOUT;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam logic [CNT_W-1:0] PLAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TLAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [PEND_W-1:0] PMAX = '1;

  state_t state, state_n;
  sel_t   sel, sel_n, pick;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic got, got_n;
  logic take, ack_sel;
  logic dec1, dec5, decb, ovf_set;
  logic [PEND_W-1:0] pend1, pend5, pendb;
  logic [INV_W-1:0]  inv1, inv5, invb;

  // Saturating up/down step; a request and a service in the
  // same cycle cancel out.
  function automatic logic [PEND_W-1:0] pnext(
    input logic [PEND_W-1:0] p,
    input logic inc,
    input logic dec
  );
    if (inc && !dec && p != PMAX) return p + PEND_W'(1);
    if (dec && !inc) return p - PEND_W'(1);
    return p;
  endfunction

  // Eligibility, priority pick and selected-ack mux.
  always_comb begin
    pick = SEL_NONE;
    if (|pend5 && |inv5)      pick = SEL_5;
    else if (|pend1 && |inv1) pick = SEL_1;
    else if (|pendb && |invb) pick = SEL_B;
    unique case (sel)
      SEL_1:   ack_sel = ack1;
      SEL_5:   ack_sel = ack5;
      SEL_B:   ack_sel = ackb;
      default: ack_sel = 1'b0;
    endcase
  end

  // Next-state logic of the service sequencer.
  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    got_n   = got;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick != SEL_NONE) begin
          state_n = DRIVE;
          sel_n   = pick;
          cnt_n   = '0;
          got_n   = 1'b0;
        end
      end
      DRIVE: begin
        if (ack_sel && !got) begin
          got_n = 1'b1;
          take  = 1'b1;
        end
        if (cnt == PLAST) begin
          cnt_n   = '0;
          state_n = (got || ack_sel) ? IDLE : WAIT_ACK;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT_ACK: begin
        if (ack_sel) begin
          take    = 1'b1;
          state_n = IDLE;
        end else if (cnt == TLAST) begin
          state_n = FAULT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = FAULT;
    endcase
  end

  assign dec1 = (state == IDLE) && (pick == SEL_1);
  assign dec5 = (state == IDLE) && (pick == SEL_5);
  assign decb = (state == IDLE) && (pick == SEL_B);

  assign ovf_set =
    (rest1_req  && !dec1 && pend1 == PMAX) ||
    (rest5_req  && !dec5 && pend5 == PMAX) ||
    (bottle_req && !decb && pendb == PMAX);

  // Sequencer state and registered actuator drives.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sel    <= SEL_NONE;
      cnt    <= '0;
      got    <= 1'b0;
      drive1 <= 1'b0;
      drive5 <= 1'b0;
      driveb <= 1'b0;
    end else begin
      state  <= state_n;
      sel    <= sel_n;
      cnt    <= cnt_n;
      got    <= got_n;
      drive1 <= (state_n == DRIVE) && (sel_n == SEL_1);
      drive5 <= (state_n == DRIVE) && (sel_n == SEL_5);
      driveb <= (state_n == DRIVE) && (sel_n == SEL_B);
    end
  end

  // Pending queues and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend1    <= '0;
      pend5    <= '0;
      pendb    <= '0;
      overflow <= 1'b0;
    end else begin
      pend1    <= pnext(pend1, rest1_req, dec1);
      pend5    <= pnext(pend5, rest5_req, dec5);
      pendb    <= pnext(pendb, bottle_req, decb);
      overflow <= overflow | ovf_set;
    end
  end

  // Inventories: refill beats an accepted drop.
  always_ff @(posedge clk) begin
    if (reset || refill) begin
      inv1 <= INV_W'(INV1_INIT);
      inv5 <= INV_W'(INV5_INIT);
      invb <= INV_W'(INVB_INIT);
    end else if (take) begin
      if (sel == SEL_1) inv1 <= inv1 - INV_W'(1);
      if (sel == SEL_5) inv5 <= inv5 - INV_W'(1);
      if (sel == SEL_B) invb <= invb - INV_W'(1);
    end
  end

  assign busy   = (state != IDLE) || |pend1 || |pend5 || |pendb;
  assign empty1 = (inv1 == '0);
  assign empty5 = (inv5 == '0);
  assign emptyb = (invb == '0);
  assign fault  = (state == FAULT);

endmodule

// File: tb/tb_vend_payout_ctrl.sv
// Bench for vend_payout_ctrl: directed scenarios plus random
// request bursts checked against a transaction-level model.
module tb_vend_payout_ctrl;

  logic clk = 1'b0;
  logic reset, rest1_req, rest5_req, bottle_req;
  logic ack1, ack5, ackb, refill;
  logic drive1, drive5, driveb, busy;
  logic empty1, empty5, emptyb, overflow, fault;

  int checks = 0;
  int fails  = 0;

  // model: index 0 = 5-lei, 1 = 1-leu, 2 = bottle (priority order)
  int mp[3];
  int mi[3];
  int init_inv[3] = '{20, 50, 30};
  bit movf;

  always #5 clk = ~clk;

  vend_payout_ctrl dut (
    .clk(clk), .reset(reset),
    .rest1_req(rest1_req), .rest5_req(rest5_req),
    .bottle_req(bottle_req),
    .ack1(ack1), .ack5(ack5), .ackb(ackb),
    .refill(refill),
    .drive1(drive1), .drive5(drive5), .driveb(driveb),
    .busy(busy),
    .empty1(empty1), .empty5(empty5), .emptyb(emptyb),
    .overflow(overflow), .fault(fault)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1; rest1_req = 0; rest5_req = 0; bottle_req = 0;
    ack1 = 0; ack5 = 0; ackb = 0; refill = 0;
    tick; tick;
    reset = 0;
  endtask

  function automatic logic any_drv();
    return drive1 | drive5 | driveb;
  endfunction

  // Waits for a service to start, acks it dly cycles after
  // the drive rises, returns once the block is idle again.
  task automatic serve(input int dly, output int typ,
                       output int width);
    typ = -1;
    width = 0;
    for (int i = 0; i < 40; i++) begin
      if (any_drv()) break;
      tick;
    end
    if (!any_drv()) return;
    typ = drive5 ? 0 : (drive1 ? 1 : 2);
    for (int j = 0; j < 60; j++) begin
      if (j > dly && !any_drv()) break;
      if (any_drv()) width++;
      ack5 = (typ == 0) && (j == dly);
      ack1 = (typ == 1) && (j == dly);
      ackb = (typ == 2) && (j == dly);
      tick;
    end
    ack1 = 0; ack5 = 0; ackb = 0;
  endtask

  function automatic int mpick();
    for (int k = 0; k < 3; k++)
      if (mp[k] > 0 && mi[k] > 0) return k;
    return -1;
  endfunction

  task automatic test_reset;
    do_reset;
    checks++;
    if ({drive1, drive5, driveb, busy, overflow, fault} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs got=%b want=000000",
               {drive1, drive5, driveb, busy, overflow, fault});
    end
    checks++;
    if ({empty1, empty5, emptyb} !== 3'b000) begin
      fails++;
      $display("FAIL reset_empty got=%b want=000",
               {empty1, empty5, emptyb});
    end
    checks++;
    if (dut.inv1 !== 8'd50 || dut.inv5 !== 8'd20 ||
        dut.invb !== 8'd30) begin
      fails++;
      $display("FAIL reset_inv got=%0d/%0d/%0d want=50/20/30",
               dut.inv1, dut.inv5, dut.invb);
    end
  endtask

  task automatic test_single;
    int hi;
    do_reset;
    rest1_req = 1;
    tick;
    rest1_req = 0;
    checks++;
    if (drive1 !== 1'b0 || dut.pend1 !== 4'd1) begin
      fails++;
      $display("FAIL single_pend drive1=%b pend1=%0d want 0/1",
               drive1, dut.pend1);
    end
    tick;
    checks++;
    if (drive1 !== 1'b1) begin
      fails++;
      $display("FAIL single_rise drive1=%b want=1", drive1);
    end
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (drive1) hi++;
      ack1 = (i == 2);
      tick;
    end
    ack1 = 0;
    checks++;
    if (hi != 4) begin
      fails++;
      $display("FAIL single_width got=%0d want=4", hi);
    end
    checks++;
    if (dut.inv1 !== 8'd49 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_done inv1=%0d busy=%b want 49/0",
               dut.inv1, busy);
    end
  endtask

  task automatic test_order;
    int t, w;
    int want[4] = '{0, 1, 1, 2};
    do_reset;
    rest5_req = 1; tick;
    rest5_req = 0; rest1_req = 1; tick;
    tick;
    rest1_req = 0; bottle_req = 1; tick;
    bottle_req = 0;
    for (int k = 0; k < 4; k++) begin
      serve(0, t, w);
      checks++;
      if (t != want[k]) begin
        fails++;
        $display("FAIL order_%0d got=%0d want=%0d", k, t, want[k]);
      end
    end
    tick;
    checks++;
    if (dut.inv5 !== 8'd19 || dut.inv1 !== 8'd48 ||
        dut.invb !== 8'd29 || busy !== 1'b0) begin
      fails++;
      $display("FAIL order_inv got=%0d/%0d/%0d busy=%b want 19/48/29/0",
               dut.inv5, dut.inv1, dut.invb, busy);
    end
  endtask

  task automatic test_late_ack;
    int t, w;
    do_reset;
    bottle_req = 1; tick; bottle_req = 0;
    serve(19, t, w);
    tick;
    checks++;
    if (t != 2 || fault !== 1'b0 || dut.invb !== 8'd29) begin
      fails++;
      $display("FAIL late_ack typ=%0d fault=%b invb=%0d want 2/0/29",
               t, fault, dut.invb);
    end
  endtask

  task automatic test_fault;
    int first, hi;
    do_reset;
    bottle_req = 1; tick; bottle_req = 0;
    for (int i = 0; i < 10; i++) begin
      if (driveb) break;
      tick;
    end
    first = -1;
    hi = 0;
    for (int j = 0; j < 30; j++) begin
      if (driveb) hi++;
      if (fault && first < 0) first = j;
      tick;
    end
    checks++;
    if (hi != 4 || first != 20) begin
      fails++;
      $display("FAIL fault_timing width=%0d at=%0d want 4/20",
               hi, first);
    end
    hi = 0;
    for (int i = 0; i < 3; i++) begin
      rest1_req = 1; tick; rest1_req = 0; tick;
    end
    for (int i = 0; i < 10; i++) begin
      if (any_drv()) hi++;
      tick;
    end
    checks++;
    if (hi != 0 || dut.pend1 !== 4'd3 || fault !== 1'b1) begin
      fails++;
      $display("FAIL fault_hold drv=%0d pend1=%0d fault=%b want 0/3/1",
               hi, dut.pend1, fault);
    end
    reset = 1; tick; reset = 0;
    checks++;
    if (fault !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL fault_clear fault=%b busy=%b want 0/0",
               fault, busy);
    end
  endtask

  task automatic test_reset_midop;
    do_reset;
    rest1_req = 1; tick; rest1_req = 0; tick; tick;
    reset = 1; tick; reset = 0;
    checks++;
    if (drive1 !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_midop drive1=%b busy=%b want 0/0",
               drive1, busy);
    end
  endtask

  task automatic test_empty;
    int t, w;
    do_reset;
    for (int k = 0; k < 20; k++) begin
      rest5_req = 1; tick; rest5_req = 0;
      serve(1, t, w);
    end
    tick;
    checks++;
    if (empty5 !== 1'b1 || dut.inv5 !== 8'd0) begin
      fails++;
      $display("FAIL empty_flag empty5=%b inv5=%0d want 1/0",
               empty5, dut.inv5);
    end
    rest5_req = 1; tick;
    rest5_req = 0; rest1_req = 1; tick;
    rest1_req = 0;
    serve(1, t, w);
    tick;
    checks++;
    if (t != 1 || dut.pend5 !== 4'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL empty_skip typ=%0d pend5=%0d busy=%b want 1/1/1",
               t, dut.pend5, busy);
    end
    refill = 1; tick; refill = 0;
    serve(1, t, w);
    tick;
    checks++;
    if (t != 0 || dut.inv5 !== 8'd19 || busy !== 1'b0) begin
      fails++;
      $display("FAIL empty_refill typ=%0d inv5=%0d busy=%b want 0/19/0",
               t, dut.inv5, busy);
    end
  endtask

  task automatic test_overflow;
    do_reset;
    rest1_req = 1;
    for (int k = 0; k < 16; k++) tick;
    checks++;
    if (dut.pend1 !== 4'd15 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_edge pend1=%0d ovf=%b want 15/0",
               dut.pend1, overflow);
    end
    for (int k = 0; k < 4; k++) tick;
    rest1_req = 0;
    for (int k = 0; k < 5; k++) tick;
    checks++;
    if (dut.pend1 !== 4'd15 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sticky pend1=%0d ovf=%b want 15/1",
               dut.pend1, overflow);
    end
  endtask

  task automatic test_refill_vs_ack;
    int t, w;
    do_reset;
    rest1_req = 1; tick; rest1_req = 0;
    serve(1, t, w);
    rest1_req = 1; tick; rest1_req = 0;
    for (int i = 0; i < 10; i++) begin
      if (drive1) break;
      tick;
    end
    ack1 = 1; refill = 1; tick;
    ack1 = 0; refill = 0;
    for (int i = 0; i < 6; i++) tick;
    checks++;
    if (dut.inv1 !== 8'd50 || busy !== 1'b0) begin
      fails++;
      $display("FAIL refill_wins inv1=%0d busy=%b want 50/0",
               dut.inv1, busy);
    end
  endtask

  task automatic test_random;
    int t, w, e, g;
    bit r[3];
    do_reset;
    mp = '{0, 0, 0};
    mi = init_inv;
    movf = 0;
    for (int rnd = 0; rnd < 40; rnd++) begin
      if ($urandom_range(0, 11) == 0) begin
        refill = 1; tick; refill = 0;
        mi = init_inv;
      end
      r[0] = ($urandom_range(0, 3) != 0);
      r[1] = $urandom_range(0, 1) == 1;
      r[2] = $urandom_range(0, 1) == 1;
      rest5_req = r[0]; rest1_req = r[1]; bottle_req = r[2];
      for (int k = 0; k < 3; k++)
        if (r[k]) begin
          if (mp[k] == 15) movf = 1;
          else mp[k]++;
        end
      tick;
      rest5_req = 0; rest1_req = 0; bottle_req = 0;
      g = 0;
      while (mpick() >= 0 && g < 20) begin
        e = mpick();
        serve($urandom_range(0, 18), t, w);
        checks++;
        if (t != e || w != 4) begin
          fails++;
          $display("FAIL rnd%0d_svc typ=%0d w=%0d want %0d/4",
                   rnd, t, w, e);
        end
        mp[e]--;
        mi[e]--;
        g++;
      end
      tick;
      checks++;
      if (dut.pend5 != mp[0] || dut.pend1 != mp[1] ||
          dut.pendb != mp[2] || dut.inv5 != mi[0] ||
          dut.inv1 != mi[1] || dut.invb != mi[2] ||
          busy !== (mp[0] + mp[1] + mp[2] != 0) ||
          empty5 !== (mi[0] == 0) || overflow !== movf) begin
        fails++;
        $display("FAIL rnd%0d_state pend=%0d/%0d/%0d inv=%0d/%0d/%0d busy=%b ovf=%b want pend=%0d/%0d/%0d inv=%0d/%0d/%0d ovf=%b",
                 rnd, dut.pend5, dut.pend1, dut.pendb,
                 dut.inv5, dut.inv1, dut.invb, busy, overflow,
                 mp[0], mp[1], mp[2], mi[0], mi[1], mi[2], movf);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_order;
    test_late_ack;
    test_fault;
    test_reset_midop;
    test_empty;
    test_overflow;
    test_refill_vs_ack;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
